// File: rtl/mseq_gen_param.sv
// mseq_gen_param: parametrised maximal-length LFSR chip generator.
// The code phase is set by advancing the LFSR k steps (seek) after loading SEED,
// so no per-shift phase table is needed for any register length.
// Ports:
//   clkin      - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - run request, accepted only while ready=1
//   shift      - code-phase shift k (all ones means k=0), sampled on accept
//   continuous - 1: repeat periods until stop, 0: one period
//   stop       - end continuous generation after the current period
//   ready      - idle, able to accept start
//   out        - chip value
//   out_valid  - out and chip_idx valid this cycle
//   epoch      - high with the last chip (chip_idx=N-1) of each period
//   chip_idx   - index of the current chip within the period
module mseq_gen_param #(
  parameter int unsigned         LENGTH = 6,
  parameter logic [LENGTH-1:0]   POLY   = LENGTH'(6'b000011),
  parameter logic [LENGTH-1:0]   SEED   = LENGTH'(6'b101010)
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] shift,
  input  logic              continuous,
  input  logic              stop,
  output logic              ready,
  output logic              out,
  output logic              out_valid,
  output logic              epoch,
  output logic [LENGTH-1:0] chip_idx
);

  localparam int unsigned       N        = (32'd1 << LENGTH) - 32'd1;
  localparam logic [LENGTH-1:0] ALL_ONES = LENGTH'(N);
  localparam logic [LENGTH-1:0] LAST_IDX = LENGTH'(N - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q;
  logic [LENGTH-1:0] lfsr_q;
  logic [LENGTH-1:0] seek_cnt_q;
  logic [LENGTH-1:0] idx_q;       // index of the chip to be registered next
  logic [LENGTH-1:0] chip_idx_q;
  logic              cont_q;
  logic              stop_req_q;
  logic              ready_q;
  logic              out_q;
  logic              out_valid_q;
  logic              epoch_q;

  // Feedback chip and the one-step advanced register
  logic              chip_c;
  logic [LENGTH-1:0] lfsr_step_c;
  logic [LENGTH-1:0] shift_k_c;

  assign chip_c      = ^(POLY & lfsr_q);
  assign lfsr_step_c = {chip_c, lfsr_q[LENGTH-1:1]};
  // A shift of N is a full period, i.e. the same phase as shift 0
  assign shift_k_c   = (shift == ALL_ONES) ? '0 : shift;

  // Sequencer: load, seek to code phase, then emit chips
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      seek_cnt_q  <= '0;
      idx_q       <= '0;
      chip_idx_q  <= '0;
      cont_q      <= 1'b0;
      stop_req_q  <= 1'b0;
      ready_q     <= 1'b1;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ready_q     <= 1'b1;
          out_valid_q <= 1'b0;
          epoch_q     <= 1'b0;
          if (start) begin
            lfsr_q     <= SEED;
            seek_cnt_q <= shift_k_c;
            cont_q     <= continuous;
            stop_req_q <= 1'b0;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            state_q    <= (shift_k_c != '0) ? S_SEEK : S_RUN;
          end
        end

        S_SEEK: begin
          lfsr_q     <= lfsr_step_c;
          seek_cnt_q <= seek_cnt_q - LENGTH'(1);
          if (stop) stop_req_q <= 1'b1;
          if (seek_cnt_q == LENGTH'(1)) state_q <= S_RUN;
        end

        S_RUN: begin
          out_q       <= chip_c;
          out_valid_q <= 1'b1;
          chip_idx_q  <= idx_q;
          lfsr_q      <= lfsr_step_c;
          if (stop) stop_req_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            epoch_q <= 1'b1;
            idx_q   <= '0;
            // A stop seen on this very edge still makes this the last period
            if (!cont_q || stop_req_q || stop) begin
              state_q    <= S_IDLE;
              ready_q    <= 1'b1;
              stop_req_q <= 1'b0;
            end
          end else begin
            epoch_q <= 1'b0;
            idx_q   <= idx_q + LENGTH'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign epoch     = epoch_q;
  assign chip_idx  = chip_idx_q;

endmodule

// File: tb/tb_mseq_gen_param.sv
// Testbench for mseq_gen_param: two instances (6-bit default, 4-bit variant),
// scoreboard queues filled by stimulus and drained by per-instance monitors.
module tb_mseq_gen_param;

  localparam int N6 = 63;
  localparam int N4 = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start6, cont6, stop6;
  logic [5:0] shift6;
  logic       ready6, out6, ov6, ep6;
  logic [5:0] idx6;
  logic       start4, cont4, stop4;
  logic [3:0] shift4;
  logic       ready4, out4, ov4, ep4;
  logic [3:0] idx4;

  always #5 clk = ~clk;

  mseq_gen_param dut6 (
    .clkin(clk), .rst(rst), .start(start6), .shift(shift6), .continuous(cont6),
    .stop(stop6), .ready(ready6), .out(out6), .out_valid(ov6), .epoch(ep6),
    .chip_idx(idx6)
  );

  mseq_gen_param #(.LENGTH(4), .POLY(4'b0011), .SEED(4'b0001)) dut4 (
    .clkin(clk), .rst(rst), .start(start4), .shift(shift4), .continuous(cont4),
    .stop(stop4), .ready(ready4), .out(out4), .out_valid(ov4), .epoch(ep4),
    .chip_idx(idx4)
  );

  typedef struct {
    bit chip;
    int idx;
    bit ep;
  } exp_t;

  exp_t q6[$];
  exp_t q4[$];
  bit   obs6[$];
  bit   obs4[$];
  exp_t e6, e4;
  bit   seq6[N6];
  bit   seq4[N4];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Shift-0 reference sequence straight from the recurrence: each chip is the
  // parity of the tapped bits, and it becomes the new top bit as the state shifts right.
  function automatic void gen_seq(input int len, input int poly, input int seed,
                                  output bit s[$]);
    int st = seed;
    s = {};
    for (int i = 0; i < (1 << len) - 1; i++) begin
      bit c = ^(poly & st);
      s.push_back(c);
      st = (st >> 1) | (int'(c) << (len - 1));
    end
  endfunction

  function automatic int ones(input bit s[$]);
    int n = 0;
    foreach (s[i]) n += int'(s[i]);
    return n;
  endfunction

  // Monitors: every valid chip must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (!rst && ov6) begin
      obs6.push_back(out6);
      if (q6.size() == 0) check("unexpected_chip6", 1, 0);
      else begin
        e6 = q6.pop_front();
        check("chip6", out6, e6.chip);
        check("idx6", idx6, e6.idx);
        check("epoch6", ep6, e6.ep);
      end
    end else if (!rst && ep6) check("epoch_no_valid6", 1, 0);
  end

  always @(negedge clk) begin
    if (!rst && ov4) begin
      obs4.push_back(out4);
      if (q4.size() == 0) check("unexpected_chip4", 1, 0);
      else begin
        e4 = q4.pop_front();
        check("chip4", out4, e4.chip);
        check("idx4", idx4, e4.idx);
        check("epoch4", ep4, e4.ep);
      end
    end else if (!rst && ep4) check("epoch_no_valid4", 1, 0);
  end

  task automatic push6(input int k, input int chips);
    for (int i = 0; i < chips; i++)
      q6.push_back('{seq6[(i + k) % N6], i % N6, (i % N6) == N6 - 1});
  endtask

  // Issue one run on dut6 (called at a negedge); returns at the negedge after the last chip.
  // stop_s: stop is high while chip stop_s is presented; abuse_at: start pulse with a new shift.
  task automatic run6(input int sh, input bit cont, input int periods,
                      input int stop_s, input int abuse_at);
    int k     = (sh == N6) ? 0 : sh;
    int total = cont ? periods * N6 : N6;
    bit idle_ok = 1'b1;
    bit contig  = 1'b1;
    push6(k, total);
    start6 = 1'b1; shift6 = 6'(sh); cont6 = cont;
    @(negedge clk);
    start6 = 1'b0;
    check("ready_low_after_accept", ready6, 0);
    for (int j = 0; j <= k; j++) begin
      if (ov6) idle_ok = 1'b0;
      @(negedge clk);
    end
    check("no_valid_before_first_chip", idle_ok, 1);
    check("first_valid", ov6, 1);
    if (k == 0) check("lfsr_step1", dut6.lfsr_q, 6'b110101);
    for (int i = 1; i < total; i++) begin
      stop6 = (i - 1 == stop_s);
      if (i - 1 == abuse_at) begin start6 = 1'b1; shift6 = 6'd20; end
      else start6 = 1'b0;
      @(negedge clk);
      if (k == 0 && i == 1) check("lfsr_step2", dut6.lfsr_q, 6'b111010);
      if (!ov6) contig = 1'b0;
      if (i < total - 1 && ready6) contig = 1'b0;
    end
    start6 = 1'b0; stop6 = 1'b0;
    check("valid_contiguous", contig, 1);
    check("ready_at_last_chip", ready6, 1);
    check("epoch_at_last_chip", ep6, 1);
  endtask

  task automatic run4(input int sh);
    int k = (sh == N4) ? 0 : sh;
    for (int i = 0; i < N4; i++)
      q4.push_back('{seq4[(i + k) % N4], i, i == N4 - 1});
    start4 = 1'b1; shift4 = 4'(sh); cont4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    check("ready4_low", ready4, 0);
    repeat (k + N4) @(negedge clk);
    check("ready4_at_last", ready4, 1);
    check("epoch4_at_last", ep4, 1);
    @(negedge clk);
    check("valid4_drop", ov4, 0);
  endtask

  initial begin
    bit s[$];
    gen_seq(6, 6'b000011, 6'b101010, s);
    foreach (seq6[i]) seq6[i] = s[i];
    gen_seq(4, 4'b0011, 4'b0001, s);
    foreach (seq4[i]) seq4[i] = s[i];

    rst = 1'b1;
    start6 = 0; cont6 = 0; stop6 = 0; shift6 = '0;
    start4 = 0; cont4 = 0; stop4 = 0; shift4 = '0;
    #1;
    check("rst_ready", ready6, 1);
    check("rst_valid", ov6, 0);
    check("rst_epoch", ep6, 0);
    check("rst_idx", idx6, 0);
    check("rst_out", out6, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Shift 0, single period
    obs6 = {};
    run6(0, 0, 1, -1, -1);
    @(negedge clk);
    check("valid_drop_single", ov6, 0);
    #1;
    check("shift0_count", obs6.size(), 63);
    check("shift0_ones", ones(obs6), 32);
    check("shift0_first6", {obs6[0], obs6[1], obs6[2], obs6[3], obs6[4], obs6[5]}, 6'b111110);

    // Shift 5, then a start pulse mid-run, then a back-to-back start
    obs6 = {};
    run6(5, 0, 1, -1, 10);
    #1;
    check("shift5_first_chip", obs6[0], 0);
    run6(7, 0, 1, -1, -1);
    @(negedge clk);

    // Shift all ones behaves like shift 0
    run6(63, 0, 1, -1, -1);
    @(negedge clk);

    // Random single-period shifts
    repeat (4) begin
      run6(int'($urandom_range(0, 63)), 0, 1, -1, -1);
      @(negedge clk);
    end

    // Continuous: stop mid period 3, then stop on the epoch edge of period 2
    run6(int'($urandom_range(0, 10)), 1, 3, 2 * N6 + 30, -1);
    @(negedge clk);
    check("cont_valid_drop", ov6, 0);
    check("cont_ready", ready6, 1);
    run6(int'($urandom_range(0, 10)), 1, 2, 2 * N6 - 2, -1);
    @(negedge clk);
    check("epoch_stop_valid_drop", ov6, 0);

    // Reset mid-SEEK
    start6 = 1'b1; shift6 = 6'd40; cont6 = 1'b0;
    @(negedge clk);
    start6 = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("seek_rst_ready", ready6, 1);
    check("seek_rst_valid", ov6, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-RUN
    push6(3, N6);
    start6 = 1'b1; shift6 = 6'd3; cont6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    repeat (24) @(negedge clk);
    #2 q6.delete(); rst = 1'b1;
    #1;
    check("run_rst_ready", ready6, 1);
    check("run_rst_valid", ov6, 0);
    check("run_rst_epoch", ep6, 0);
    check("run_rst_idx", idx6, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs6 = {};
    run6(0, 0, 1, -1, -1);
    @(negedge clk);
    #1;
    check("post_rst_first6", {obs6[0], obs6[1], obs6[2], obs6[3], obs6[4], obs6[5]}, 6'b111110);

    // 4-bit instance
    obs4 = {};
    run4(0);
    #1;
    check("len4_count", obs4.size(), 15);
    check("len4_ones", ones(obs4), 8);
    @(negedge clk);
    run4(int'($urandom_range(1, 14)));
    run4(15);

    repeat (2) @(negedge clk);
    check("q6_drained", q6.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
